// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   tx_state_e     - transmitter FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DATA_BITS      - payload bits per frame (8N1)
//   DEFAULT_CLK_HZ - default input clock frequency
//   DEFAULT_BAUD   - default line rate
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS      = 8;
  localparam int DEFAULT_CLK_HZ = 12000000;
  localparam int DEFAULT_BAUD   = 115200;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous register-array FIFO feeding the UART transmitter.
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset (empties the FIFO)
//   push      in   write request; ignored while full
//   push_data in   WIDTH-bit data to store
//   pop       in   read request; ignored while empty
//   head      out  oldest entry (valid while not empty)
//   full      out  level == DEPTH
//   empty     out  level == 0
//   level     out  occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == LW'(0));
  assign level     = level_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array and write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer and occupancy; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter with optional CTS# flow control.
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   data_in  in   byte to send
//   write    in   data_in valid; accepted when write && ready
//   ready    out  FIFO not full
//   tx       out  registered serial line, idle high
//   cts_n    in   clear-to-send, active-low, asynchronous to clk
//   busy     out  frame in progress or FIFO non-empty
//   level    out  FIFO occupancy
// Build option: define UART_TX_CTS_EN to gate frame launches on the
// synchronised cts_n; without it cts_n is ignored and no synchroniser exists.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    data_in,
  input  logic                          write,
  output logic                          ready,
  output logic                          tx,
  input  logic                          cts_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BIT_TICKS = CLK_HZ / BAUD;
  localparam int CNT_W     = $clog2(BIT_TICKS);
  localparam int LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(BIT_TICKS - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e            state_r, state_next_s;
  logic [CNT_W-1:0]     tick_r, tick_next_s;
  logic [2:0]           bit_idx_r, bit_idx_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 tx_r, tx_next_s;
  logic                 pop_s;
  logic                 launch_ok_s;
  logic [7:0]           fifo_head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [LW-1:0]        level_s;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (write),
    .push_data (data_in),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (level_s)
  );

`ifdef UART_TX_CTS_EN
  logic cts_meta_r;
  logic cts_sync_r;

  // Two-flop synchroniser for the asynchronous cts_n pin; resets to "not clear".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= cts_n;
      cts_sync_r <= cts_meta_r;
    end
  end

  assign launch_ok_s = !cts_sync_r;
`else
  logic cts_unused_s;
  assign cts_unused_s = cts_n;
  assign launch_ok_s  = 1'b1;
`endif

  assign ready = !fifo_full_s;
  assign tx    = tx_r;
  assign level = level_s;
  assign busy  = (state_r != TX_IDLE) || (level_s != LW'(0));

  // FSM next-state, datapath next values and the value the tx flop will hold.
  always_comb begin
    state_next_s   = state_r;
    tick_next_s    = tick_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    tx_next_s      = tx_r;
    pop_s          = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (!fifo_empty_s && launch_ok_s) begin
          pop_s        = 1'b1;
          shift_next_s = fifo_head_s;
          tick_next_s  = TICK_MAX;
          state_next_s = TX_START;
          tx_next_s    = 1'b0;
        end else begin
          state_next_s = TX_IDLE;
          tx_next_s    = 1'b1;
        end
      end
      TX_START: begin
        if (tick_r == CNT_W'(0)) begin
          state_next_s   = TX_DATA;
          bit_idx_next_s = 3'd0;
          tick_next_s    = TICK_MAX;
          tx_next_s      = shift_r[0];
        end else begin
          tick_next_s = tick_r - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tick_r == CNT_W'(0)) begin
          tick_next_s = TICK_MAX;
          if (bit_idx_r == LAST_BIT) begin
            state_next_s = TX_STOP;
            tx_next_s    = 1'b1;
          end else begin
            // Shift right so the next bit to send is always at position 0.
            bit_idx_next_s = bit_idx_r + 3'd1;
            shift_next_s   = {1'b0, shift_r[DATA_BITS-1:1]};
            tx_next_s      = shift_r[1];
          end
        end else begin
          tick_next_s = tick_r - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tick_r == CNT_W'(0)) begin
          // End of stop bit is the second launch decision point: chain frames with no gap.
          if (!fifo_empty_s && launch_ok_s) begin
            pop_s        = 1'b1;
            shift_next_s = fifo_head_s;
            tick_next_s  = TICK_MAX;
            state_next_s = TX_START;
            tx_next_s    = 1'b0;
          end else begin
            state_next_s = TX_IDLE;
            tx_next_s    = 1'b1;
          end
        end else begin
          tick_next_s = tick_r - CNT_W'(1);
        end
      end
      default: begin
        state_next_s = TX_IDLE;
        tx_next_s    = 1'b1;
      end
    endcase
  end

  // FSM state, datapath registers and the glitch-free tx flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= TX_IDLE;
      tick_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= '0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      tick_r    <= tick_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
      tx_r      <= tx_next_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int BT     = 10;
  localparam int FRAME  = 10 * BT;
  localparam int DEPTH  = 16;
  localparam int LW     = 5;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          write   = 1'b0;
  logic          cts_n   = 1'b0;
  logic          ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] level;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  bit mon_en      = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] rx_byte_q[$];
  int         rx_time_q[$];
  bit         rx_good_q[$];

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .write   (write),
    .ready   (ready),
    .tx      (tx),
    .cts_n   (cts_n),
    .busy    (busy),
    .level   (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Line monitor: detects a start edge, samples mid-bit, pushes decoded frames.
  always begin : monitor
    bit         prev;
    bit         abort;
    bit         good;
    logic [7:0] b;
    int         t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && tx === 1'b0) begin
        t0 = cycle; abort = 1'b0; good = 1'b1; b = 8'h00;
        for (int k = 0; k < 10; k++) begin
          for (int w = 0; w < ((k == 0) ? BT / 2 : BT); w++) begin
            @(negedge clk);
            if (!mon_en) begin abort = 1'b1; break; end
          end
          if (abort) break;
          if (k == 0)      good = good && (tx === 1'b0);
          else if (k == 9) good = good && (tx === 1'b1);
          else             b[k-1] = tx;
        end
        if (!abort) begin
          for (int w = 0; w < BT / 2 - 1; w++) @(negedge clk);
          rx_byte_q.push_back(b);
          rx_time_q.push_back(t0);
          rx_good_q.push_back(good);
        end
      end
      prev = tx;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_write(input logic [7:0] b, input bit accept);
    data_in = b;
    write   = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic wait_rx(input int n, input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (rx_byte_q.size() >= n) break;
      @(negedge clk);
    end
    got = (rx_byte_q.size() >= n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_single_byte();
    bit got;
    logic [7:0] e, a;
    @(negedge clk);
    drive_write(8'hA5, 1'b1);
    @(negedge clk);
    vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL single_level: got %0d expected 1", level); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_still_idle: got %b expected 1", tx); end
    @(negedge clk);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_start_latency: got %b expected 0", tx); end
    repeat (FRAME - 1) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_last_stop: got %b expected 1", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
    wait_rx(1, 3 * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL single_rx_timeout: got 0 frames expected 1");
    end else begin
      e = exp_q.pop_front(); a = rx_byte_q.pop_front(); void'(rx_time_q.pop_front());
      if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL single_data: got %h expected %h with valid framing", a, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [7:0] e, a;
    logic [LW-1:0] lv [3];
    int t [3];
    @(negedge clk);
    drive_write(8'h00, 1'b1); lv[0] = level;
    drive_write(8'hFF, 1'b1); lv[1] = level;
    drive_write(8'h55, 1'b1); lv[2] = level;
    // The first byte is popped on the edge after it lands, so occupancy is 1,1,2.
    vectors++; if (lv[0] !== 5'd1) begin miscompares++; $display("FAIL b2b_level0: got %0d expected 1", lv[0]); end
    vectors++; if (lv[1] !== 5'd1) begin miscompares++; $display("FAIL b2b_level1: got %0d expected 1", lv[1]); end
    vectors++; if (lv[2] !== 5'd2) begin miscompares++; $display("FAIL b2b_level2: got %0d expected 2", lv[2]); end
    wait_rx(3, 4 * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL b2b_rx_timeout: got %0d frames expected 3", rx_byte_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front(); a = rx_byte_q.pop_front(); t[i] = rx_time_q.pop_front();
        vectors++;
        if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL b2b_data%0d: got %h expected %h with valid framing", i, a, e); end
      end
      vectors++; if (t[1] - t[0] != FRAME) begin miscompares++; $display("FAIL b2b_gap01: got %0d expected %0d", t[1] - t[0], FRAME); end
      vectors++; if (t[2] - t[1] != FRAME) begin miscompares++; $display("FAIL b2b_gap12: got %0d expected %0d", t[2] - t[1], FRAME); end
    end
    repeat (3) @(negedge clk);
    vectors++; if (level !== 5'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got level=%0d busy=%b expected 0 0", level, busy); end
  endtask

  task automatic test_full_fifo();
    bit got;
    int n_acc;
    int t_prev;
    logic [7:0] e, a;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b1;
    n_acc = DEPTH;
`else
    // Without flow control the head byte leaves on the second write, so one more fits.
    n_acc = DEPTH + 1;
`endif
    repeat (4) @(negedge clk);
    for (int i = 0; i <= n_acc; i++) begin
      drive_write(8'(i * 37 + 5), i < n_acc);
      if (i == n_acc - 1) begin
        vectors++; if (ready !== 1'b0 || level !== 5'd16) begin miscompares++; $display("FAIL full_after_fill: got ready=%b level=%0d expected 0 16", ready, level); end
      end
    end
    vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL full_drop_level: got %0d expected 16", level); end
`ifdef UART_TX_CTS_EN
    repeat (30) @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL full_cts_hold: got tx=%b busy=%b expected 1 1", tx, busy); end
    cts_n = 1'b0;
`endif
    wait_rx(n_acc, (n_acc + 2) * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL full_rx_timeout: got %0d frames expected %0d", rx_byte_q.size(), n_acc);
    end else begin
      t_prev = 0;
      for (int i = 0; i < n_acc; i++) begin
        e = exp_q.pop_front(); a = rx_byte_q.pop_front();
        vectors++;
        if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL full_data%0d: got %h expected %h with valid framing", i, a, e); end
        if (i > 0) begin
          vectors++; if (rx_time_q[0] - t_prev != FRAME) begin miscompares++; $display("FAIL full_gap%0d: got %0d expected %0d", i, rx_time_q[0] - t_prev, FRAME); end
        end
        t_prev = rx_time_q.pop_front();
      end
    end
    repeat (FRAME) @(negedge clk);
    vectors++; if (rx_byte_q.size() != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL full_extra_frame: got %0d extra frames busy=%b expected 0 0", rx_byte_q.size(), busy); end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts_midframe();
    bit got;
    int n;
    logic [7:0] e, a;
    cts_n = 1'b0;
    repeat (4) @(negedge clk);
    drive_write(8'hC3, 1'b1);
    drive_write(8'h96, 1'b1);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    repeat (35) @(negedge clk);
    cts_n = 1'b1;
    wait_rx(1, 2 * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL cts_frame1_timeout: got 0 frames expected 1");
    end else begin
      e = exp_q.pop_front(); a = rx_byte_q.pop_front(); void'(rx_time_q.pop_front());
      if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL cts_frame1_data: got %h expected %h with valid framing", a, e); end
    end
    repeat (40) @(negedge clk);
    vectors++; if (tx !== 1'b1 || level !== 5'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL cts_wait: got tx=%b level=%0d busy=%b expected 1 1 1", tx, level, busy); end
    @(posedge clk);
    #1 cts_n = 1'b0;
    n = 0;
    while (n < 5) begin @(negedge clk); n++; if (tx === 1'b0) break; end
    vectors++; if (tx !== 1'b0 || n > 4) begin miscompares++; $display("FAIL cts_release_latency: got %0d cycles expected at most 4", n); end
    wait_rx(1, 2 * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL cts_frame2_timeout: got 0 frames expected 1");
    end else begin
      e = exp_q.pop_front(); a = rx_byte_q.pop_front(); void'(rx_time_q.pop_front());
      if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL cts_frame2_data: got %h expected %h with valid framing", a, e); end
    end
  endtask
`else
  task automatic test_cts_ignored();
    bit got;
    logic [7:0] e, a;
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    drive_write(8'h3C, 1'b1);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL nocts_start: got %b expected 0", tx); end
    wait_rx(1, 2 * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL nocts_rx_timeout: got 0 frames expected 1");
    end else begin
      e = exp_q.pop_front(); a = rx_byte_q.pop_front(); void'(rx_time_q.pop_front());
      if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL nocts_data: got %h expected %h with valid framing", a, e); end
    end
    cts_n = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe();
    bit got;
    int n;
    logic [7:0] e, a;
    cts_n  = 1'b0;
    mon_en = 1'b0;
    repeat (4) @(negedge clk);
    drive_write(8'h00, 1'b0);
    drive_write(8'h81, 1'b0);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    repeat (45) @(negedge clk);
    vectors++; if (tx !== 1'b0 || level !== 5'd1) begin miscompares++; $display("FAIL rstmid_bit3: got tx=%b level=%0d expected 0 1", tx, level); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_async: got %b expected 1", tx); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (level !== 5'd0 || ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_after: got level=%0d ready=%b busy=%b tx=%b expected 0 1 0 1", level, ready, busy, tx); end
    rx_byte_q.delete(); rx_time_q.delete(); rx_good_q.delete(); exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    drive_write(8'h5A, 1'b1);
    wait_rx(1, 2 * FRAME, got);
    vectors++;
    if (!got) begin
      miscompares++; $display("FAIL rstmid_rx_timeout: got 0 frames expected 1");
    end else begin
      e = exp_q.pop_front(); a = rx_byte_q.pop_front(); void'(rx_time_q.pop_front());
      if (a !== e || rx_good_q.pop_front() !== 1'b1) begin miscompares++; $display("FAIL rstmid_fifo_flushed: got %h expected %h with valid framing", a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
`ifdef UART_TX_CTS_EN
    test_cts_midframe();
`else
    test_cts_ignored();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
